// File: rtl/mux_rr_arb.sv
// mux_rr_arb: registered N-to-1 valid/ready multiplexer driven by an internal arbiter.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_data/in_valid     packed channel data (channel i at [i*DATA_WIDTH +: DATA_WIDTH]) and valids
//   in_ready             one-hot (or zero) acknowledge to the granted channel
//   out_data/out_valid   registered selected beat, out_ready is the downstream accept
//   out_sel              index of the channel that supplied out_data
// Optional: define MUX_RR_ARB_LOCK_EN to add in_last/out_last and hold the grant for whole packets.
module mux_rr_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 8,
    parameter int ARB_MODE   = 0,
    parameter int SEL_W      = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_valid,
`ifdef MUX_RR_ARB_LOCK_EN
    input  logic [NUM_IN-1:0]            in_last,
    output logic                         out_last,
`endif
    output logic [NUM_IN-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SEL_W-1:0]             out_sel
);
    logic [DATA_WIDTH-1:0] r_data;
    logic [SEL_W-1:0]      r_sel, r_ptr, w_grant, w_ptr_nxt;
    logic                  r_valid, w_any, w_load, w_xfer, w_locked;
`ifdef MUX_RR_ARB_LOCK_EN
    logic r_locked, r_last;
    assign w_locked = r_locked;
    assign out_last = r_last;
`else
    assign w_locked = 1'b0;
`endif
    assign w_load = !r_valid | out_ready;
    assign w_xfer = w_load & w_any & !rst;
    assign in_ready = w_xfer ? (NUM_IN'(1) << w_grant) : '0;
    assign w_ptr_nxt = (w_grant == SEL_W'(NUM_IN - 1)) ? '0 : w_grant + 1'b1;
    assign out_data = r_data;
    assign out_valid = r_valid;
    assign out_sel = r_sel;
    // Search starts at the pointer (round-robin) or at 0 (fixed priority); first valid wins.
    // A locked packet owns the grant, and the owner is the channel last loaded into r_sel.
    always_comb begin
        int j;
        w_grant = '0;
        w_any = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            j = (ARB_MODE == 0) ? int'(r_ptr) + k : k;
            if (j >= NUM_IN) j -= NUM_IN;
            if (!w_any && in_valid[j]) begin
                w_any = 1'b1;
                w_grant = SEL_W'(j);
            end
        end
        if (w_locked) begin
            w_any = in_valid[r_sel];
            w_grant = r_sel;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data <= '0;
            r_sel <= '0;
            r_ptr <= '0;
`ifdef MUX_RR_ARB_LOCK_EN
            r_locked <= 1'b0;
            r_last <= 1'b0;
`endif
        end else if (w_load) begin
            r_valid <= w_any;
            if (w_any) begin
                r_data <= in_data[w_grant*DATA_WIDTH +: DATA_WIDTH];
                r_sel <= w_grant;
`ifdef MUX_RR_ARB_LOCK_EN
                r_last <= in_last[w_grant];
                r_locked <= !in_last[w_grant];
                if (in_last[w_grant]) r_ptr <= w_ptr_nxt;
`else
                r_ptr <= w_ptr_nxt;
`endif
            end
        end
    end
endmodule

// File: tb/tb_mux_rr_arb.sv
// tb_mux_rr_arb: directed self-checking bench for mux_rr_arb (8-input RR, 5-input RR, 8-input fixed priority)
module tb_mux_rr_arb;
    logic clk = 1'b0;
    logic rst;
    logic [255:0] d8, dp;
    logic [159:0] d5;
    logic [7:0] v8, rdy8, vp, rdyp;
    logic [4:0] v5, rdy5;
    logic [31:0] od8, od5, odp;
    logic ov8, ov5, ovp, or8, or5, orp;
    logic [2:0] os8, os5, osp;
`ifdef MUX_RR_ARB_LOCK_EN
    logic [7:0] l8;
    logic [4:0] l5;
    logic [7:0] lp;
    logic ol8, ol5, olp;
`endif
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_rr_arb #(.DATA_WIDTH(32), .NUM_IN(8), .ARB_MODE(0)) u_rr8 (
        .clk(clk), .rst(rst), .in_data(d8), .in_valid(v8),
`ifdef MUX_RR_ARB_LOCK_EN
        .in_last(l8), .out_last(ol8),
`endif
        .in_ready(rdy8), .out_data(od8), .out_valid(ov8), .out_ready(or8), .out_sel(os8));

    mux_rr_arb #(.DATA_WIDTH(32), .NUM_IN(5), .ARB_MODE(0)) u_rr5 (
        .clk(clk), .rst(rst), .in_data(d5), .in_valid(v5),
`ifdef MUX_RR_ARB_LOCK_EN
        .in_last(l5), .out_last(ol5),
`endif
        .in_ready(rdy5), .out_data(od5), .out_valid(ov5), .out_ready(or5), .out_sel(os5));

    mux_rr_arb #(.DATA_WIDTH(32), .NUM_IN(8), .ARB_MODE(1)) u_fp8 (
        .clk(clk), .rst(rst), .in_data(dp), .in_valid(vp),
`ifdef MUX_RR_ARB_LOCK_EN
        .in_last(lp), .out_last(olp),
`endif
        .in_ready(rdyp), .out_data(odp), .out_valid(ovp), .out_ready(orp), .out_sel(osp));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        v8 = 8'hFF; v5 = '0; vp = '0;
        or8 = 1'b1; or5 = 1'b1; orp = 1'b1;
`ifdef MUX_RR_ARB_LOCK_EN
        l8 = 8'hFF; l5 = 5'h1F; lp = 8'hFF;
`endif
        for (int i = 0; i < 8; i++) begin
            d8[i*32 +: 32] = 32'hA0 + i;
            dp[i*32 +: 32] = 32'hA0 + i;
        end
        for (int i = 0; i < 5; i++) d5[i*32 +: 32] = 32'hA0 + i;
        tick();
        tick();
        chk("rst_valid", ov8, 0);
        chk("rst_data", od8, 0);
        chk("rst_sel", os8, 0);
        chk("rst_ready", rdy8, 0);
        rst = 1'b0;
        #1 chk("first_grant", rdy8, 8'h01);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("rr_sel", os8, k % 8);
            chk("rr_data", od8, 32'hA0 + k % 8);
            chk("rr_valid", ov8, 1);
        end
        v8 = '0;
        tick();
        chk("drain_valid", ov8, 0);
        d8[3*32 +: 32] = 32'hDEADBEEF;
        d8[5*32 +: 32] = 32'h55;
        v8 = 8'h08;
        or8 = 1'b0;
        #1 chk("bp_load_ready", rdy8, 8'h08);
        tick();
        v8 = 8'h20;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_data", od8, 32'hDEADBEEF);
            chk("bp_sel", os8, 3);
            chk("bp_valid", ov8, 1);
            chk("bp_ready", rdy8, 0);
            tick();
        end
        or8 = 1'b1;
        #1 chk("bp_refill_ready", rdy8, 8'h20);
        tick();
        chk("bp_next_sel", os8, 5);
        chk("bp_next_data", od8, 32'h55);
        v8 = '0;
        tick();
        chk("bp_no_dup", ov8, 0);
        v8 = 8'hFF;
        or8 = 1'b0;
        tick();
        chk("mid_sel", os8, 6);
        chk("mid_valid", ov8, 1);
        rst = 1'b1;
        #1 chk("mid_rst_ready", rdy8, 0);
        tick();
        chk("mid_rst_valid", ov8, 0);
        rst = 1'b0;
        v8 = '0;
        or8 = 1'b1;
        v5 = 5'b01000;
        tick();
        chk("w5_sel3", os5, 3);
        v5 = 5'b00101;
        #1 chk("w5_ready_wrap", rdy5, 5'b00001);
        tick();
        chk("w5_sel0", os5, 0);
        chk("w5_data0", od5, 32'hA0);
        tick();
        chk("w5_sel2", os5, 2);
        chk("w5_data2", od5, 32'hA2);
        tick();
        chk("w5_sel0b", os5, 0);
        v5 = '0;
        vp = 8'b1001_0100;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fp_sel", osp, 2);
            chk("fp_ready", rdyp, 8'h04);
        end
        vp = 8'b1001_0000;
        tick();
        chk("fp_sel4", osp, 4);
        chk("fp_data4", odp, 32'hA4);
        vp = '0;
`ifdef MUX_RR_ARB_LOCK_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        l8 = 8'h01;
        v8 = 8'h01;
        tick();
        chk("lk_pre_sel", os8, 0);
        v8 = 8'h03;
        for (int b = 0; b < 3; b++) begin
            l8[1] = (b == 2);
            tick();
            chk("lk_sel", os8, 1);
            chk("lk_last", ol8, b == 2);
        end
        tick();
        chk("lk_release_sel", os8, 0);
        l8 = 8'h01;
        v8 = 8'h02;
        tick();
        chk("lk_mid_sel", os8, 1);
        v8 = 8'h03;
        #1 chk("lk_hold_ready", rdy8, 8'h02);
        rst = 1'b1;
        tick();
        chk("lk_rst_valid", ov8, 0);
        rst = 1'b0;
        #1 chk("lk_rst_ready", rdy8, 8'h01);
        tick();
        chk("lk_rst_sel", os8, 0);
        v8 = '0;
`endif
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
